// File: rtl/rns_skid_stage_if.sv
// Handshake bundle for the residue skid stage. The producer/consumer side uses
// the master modport and the stage itself uses the slave modport.
interface rns_skid_stage_if #(
   parameter int DATA_WIDTH = 18,
   parameter int CNT_WIDTH  = 16
);
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_err;
   logic [CNT_WIDTH-1:0]  err_count;
   logic [1:0]            occupancy;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_err, err_count, occupancy
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_err, err_count, occupancy
   );
endinterface

// File: rtl/rns_skid_stage.sv
// Two-entry skid stage for residue digits: registered in_ready, strict FIFO order,
// per-digit range tag and a saturating count of out-of-range digits accepted.
module rns_skid_stage #(
   parameter int DATA_WIDTH = 18,
   parameter int MODULUS    = 262139,
   parameter int CNT_WIDTH  = 16
) (
   input logic               clk,
   input logic               sclr,
   rns_skid_stage_if.slave   s_bus
);
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   localparam logic [DATA_WIDTH:0]  MOD_L   = MODULUS[DATA_WIDTH:0];
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   state_t                r_state;
   logic                  r_in_ready;
   logic                  r_out_valid;
   logic [DATA_WIDTH-1:0] r_main_data;
   logic                  r_main_err;
   logic [DATA_WIDTH-1:0] r_skid_data;
   logic                  r_skid_err;
   logic [CNT_WIDTH-1:0]  r_err_count;

   logic w_in_xfer;
   logic w_out_xfer;
   logic w_in_err;

   assign w_in_xfer  = s_bus.in_valid & r_in_ready;
   assign w_out_xfer = r_out_valid & s_bus.out_ready;
   assign w_in_err   = ({1'b0, s_bus.in_data} >= MOD_L);

   // NOTE: every register here, data included, is reset so out_* read 0 after sclr;
   // all state updates use non-blocking assignments so branches see pre-edge values.
   always_ff @(posedge clk) begin
      if (sclr) begin
         r_state     <= EMPTY;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_main_data <= '0;
         r_main_err  <= 1'b0;
         r_skid_data <= '0;
         r_skid_err  <= 1'b0;
         r_err_count <= '0;
      end else begin
         if (w_in_xfer && w_in_err && (r_err_count != CNT_MAX))
            r_err_count <= r_err_count + 1'b1;

         unique case (r_state)
            EMPTY: begin
               r_in_ready <= 1'b1;
               if (w_in_xfer) begin
                  r_main_data <= s_bus.in_data;
                  r_main_err  <= w_in_err;
                  r_out_valid <= 1'b1;
                  r_state     <= ONE;
               end
            end
            ONE: begin
               r_in_ready <= 1'b1;
               if (w_in_xfer && !w_out_xfer) begin
                  r_skid_data <= s_bus.in_data;
                  r_skid_err  <= w_in_err;
                  r_in_ready  <= 1'b0;
                  r_state     <= FULL;
               end else if (!w_in_xfer && w_out_xfer) begin
                  r_out_valid <= 1'b0;
                  r_state     <= EMPTY;
               end else if (w_in_xfer && w_out_xfer) begin
                  r_main_data <= s_bus.in_data;
                  r_main_err  <= w_in_err;
               end
            end
            FULL: begin
               r_in_ready <= 1'b0;
               if (w_out_xfer) begin
                  r_main_data <= r_skid_data;
                  r_main_err  <= r_skid_err;
                  r_in_ready  <= 1'b1;
                  r_state     <= ONE;
               end
            end
            default: begin
               r_state     <= EMPTY;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign s_bus.in_ready  = r_in_ready;
   assign s_bus.out_valid = r_out_valid;
   assign s_bus.out_data  = r_main_data;
   assign s_bus.out_err   = r_main_err;
   assign s_bus.err_count = r_err_count;
   assign s_bus.occupancy = r_state;
endmodule

// File: tb/tb_rns_skid_stage.sv
// Bench for rns_skid_stage: directed scenarios with literal expectations plus a
// random phase, all compared each cycle against a queue-based reference model.
module tb_rns_skid_stage;
   localparam int DW  = 18;
   localparam int MOD = 262139;

   logic clk = 1'b0;
   logic sclr = 1'b1;
   logic          tb_in_valid = 1'b0;
   logic [DW-1:0] tb_in_data  = '0;
   logic          tb_out_ready = 1'b0;

   always #5 clk = ~clk;

   rns_skid_stage_if #(.DATA_WIDTH(DW), .CNT_WIDTH(16)) u_if ();
   rns_skid_stage_if #(.DATA_WIDTH(DW), .CNT_WIDTH(2))  u_if_sat ();

   assign u_if.in_valid      = tb_in_valid;
   assign u_if.in_data       = tb_in_data;
   assign u_if.out_ready     = tb_out_ready;
   assign u_if_sat.in_valid  = tb_in_valid;
   assign u_if_sat.in_data   = tb_in_data;
   assign u_if_sat.out_ready = tb_out_ready;

   rns_skid_stage #(.DATA_WIDTH(DW), .MODULUS(MOD), .CNT_WIDTH(16)) u_dut (
      .clk  (clk),
      .sclr (sclr),
      .s_bus(u_if)
   );

   rns_skid_stage #(.DATA_WIDTH(DW), .MODULUS(MOD), .CNT_WIDTH(2)) u_dut_sat (
      .clk  (clk),
      .sclr (sclr),
      .s_bus(u_if_sat)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [DW-1:0] d;
      logic          e;
   } beat_t;

   beat_t q[$];
   beat_t last_head = '{d: '0, e: 1'b0};
   bit    exp_rdy   = 1'b0;
   int    raw_errs  = 0;
   bit    chk_en    = 1'b0;

   always @(posedge clk) begin
      bit in_x, out_x;
      if (sclr) begin
         q.delete();
         exp_rdy   = 1'b0;
         raw_errs  = 0;
         last_head = '{d: '0, e: 1'b0};
      end else begin
         in_x  = tb_in_valid && exp_rdy;
         out_x = (q.size() > 0) && tb_out_ready;
         if (out_x) void'(q.pop_front());
         if (in_x) begin
            q.push_back('{d: tb_in_data, e: (int'(tb_in_data) >= MOD)});
            if (int'(tb_in_data) >= MOD) raw_errs++;
         end
         exp_rdy = (q.size() < 2);
         if (q.size() > 0) last_head = q[0];
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("m_out_valid", u_if.out_valid, (q.size() > 0));
         check("m_in_ready",  u_if.in_ready,  exp_rdy);
         check("m_occupancy", u_if.occupancy, q.size());
         check("m_out_data",  u_if.out_data,  last_head.d);
         check("m_out_err",   u_if.out_err,   last_head.e);
         check("m_err_count", u_if.err_count, (raw_errs > 65535) ? 65535 : raw_errs);
         check("s_out_valid", u_if_sat.out_valid, (q.size() > 0));
         check("s_in_ready",  u_if_sat.in_ready,  exp_rdy);
         check("s_out_data",  u_if_sat.out_data,  last_head.d);
         check("s_err_count", u_if_sat.err_count, (raw_errs > 3) ? 3 : raw_errs);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- directed + random stimulus ----------------
   initial begin
      // initial reset
      repeat (3) step();
      chk_en = 1'b1;
      check("rst_out_valid", u_if.out_valid, 0);
      check("rst_in_ready",  u_if.in_ready,  0);
      check("rst_occupancy", u_if.occupancy, 0);
      check("rst_out_data",  u_if.out_data,  0);
      check("rst_err_count", u_if.err_count, 0);
      sclr = 1'b0;
      step();
      check("rel_in_ready", u_if.in_ready, 1);

      // back-to-back stream with downstream always ready
      tb_out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tb_in_valid = 1'b1;
         tb_in_data  = DW'(i);
         step();
         check("stream_data", u_if.out_data, i);
         check("stream_rdy",  u_if.in_ready, 1);
         check("stream_occ",  u_if.occupancy, 1);
      end
      tb_in_valid = 1'b0;
      step();
      check("stream_drained", u_if.out_valid, 0);

      // backpressure: 5,6 held, 7 waits upstream
      tb_out_ready = 1'b0;
      tb_in_valid  = 1'b1;
      tb_in_data   = 18'd5; step();
      tb_in_data   = 18'd6; step();
      tb_in_data   = 18'd7; step();
      step();
      check("bp_occ",   u_if.occupancy, 2);
      check("bp_rdy",   u_if.in_ready,  0);
      check("bp_head",  u_if.out_data,  5);
      tb_out_ready = 1'b1;
      step();
      check("bp_out6", u_if.out_data, 6);
      step();
      check("bp_out7", u_if.out_data, 7);
      tb_in_valid = 1'b0;
      step();
      check("bp_empty",  u_if.out_valid, 0);
      check("bp_retain", u_if.out_data,  7);

      // mid-stream sclr with two entries held
      tb_out_ready = 1'b0;
      tb_in_valid  = 1'b1;
      tb_in_data   = 18'd1; step();
      tb_in_data   = 18'd2; step();
      check("pre_sclr_occ", u_if.occupancy, 2);
      sclr = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("sclr_valid", u_if.out_valid, 0);
         check("sclr_data",  u_if.out_data,  0);
         check("sclr_rdy",   u_if.in_ready,  0);
         check("sclr_occ",   u_if.occupancy, 0);
      end
      sclr = 1'b0;
      tb_in_valid  = 1'b0;
      tb_out_ready = 1'b1;
      step();
      check("post_sclr_rdy",   u_if.in_ready,  1);
      check("post_sclr_valid", u_if.out_valid, 0);
      step();
      check("post_sclr_quiet", u_if.out_valid, 0);

      // range boundary
      tb_in_valid = 1'b1;
      tb_in_data = 18'd262138; step();
      check("rng_d0", u_if.out_data, 262138);
      check("rng_e0", u_if.out_err,  0);
      tb_in_data = 18'd262139; step();
      check("rng_d1", u_if.out_data, 262139);
      check("rng_e1", u_if.out_err,  1);
      tb_in_data = 18'd262143; step();
      check("rng_d2", u_if.out_data, 262143);
      check("rng_e2", u_if.out_err,  1);
      tb_in_valid = 1'b0;
      step();
      check("rng_cnt", u_if.err_count, 2);

      // saturation of the narrow counter from zero
      sclr = 1'b1; step();
      sclr = 1'b0; step();
      tb_in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tb_in_data = DW'(262140 + (i % 4));
         step();
         check("sat_cnt",  u_if_sat.err_count, (i < 3) ? i + 1 : 3);
         check("wide_cnt", u_if.err_count, i + 1);
      end
      tb_in_valid = 1'b0;
      step();

      // random traffic against the model
      for (int i = 0; i < 25000; i++) begin
         tb_in_valid  = ($urandom_range(0, 3) != 0);
         tb_out_ready = ($urandom_range(0, 2) != 0);
         if ($urandom_range(0, 7) == 0)
            tb_in_data = DW'($urandom_range(MOD, 262143));
         else
            tb_in_data = DW'($urandom_range(0, MOD - 1));
         step();
      end
      tb_in_valid  = 1'b0;
      tb_out_ready = 1'b1;
      repeat (3) step();
      check("final_empty", u_if.out_valid, 0);

      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
